ts_packet_arbiter: RTL and testbench
====================================

TS_PACKET_ARBITER -- requirements
Module: ts_packet_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (2..8).
REQ-002 Parameter PKT_LEN, default 188, bytes per TS packet (≥4).
REQ-003 CLK  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 CH_MASK  input  N_CH  per-channel enable; 1 = channel may be granted.
REQ-006 PRIO_MODE  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 NULL_EN  input  1  1 = emit null packets when no channel is eligible.
REQ-008 GOT_FULL_PACKET  input  N_CH  channel i holds at least one complete packet in its FIFO.
REQ-009 DATA_IN_BUS  input  8*N_CH  channel i byte on bits [8i+7:8i], valid the cycle after RD_REQ[i].
REQ-010 RD_REQ  output  N_CH  per-channel FIFO read strobe; at most one bit high per cycle.
REQ-011 DATA_OUT  output  8  muxed TS byte.
REQ-012 D_VALID_OUT  output  1  DATA_OUT valid.
REQ-013 P_SYNC_OUT  output  1  high with the first byte of each output packet.
REQ-014 ACTIVE_CH  output  4  index of the channel currently being output; 4'hF = null packet or idle.
REQ-015 SYNC_ERR  output  1  one-cycle pulse when a granted packet's first byte is not 8'h47.

Function
REQ-016 The FSM SHALL have three states: IDLE, READ and NULL.
REQ-017 In IDLE, eligible = GOT_FULL_PACKET & CH_MASK, evaluated every cycle.
REQ-018 IDLE with eligible ≠ 0: grant one channel and enter READ on the next cycle.
REQ-019 Fixed mode: grant the lowest-index eligible channel.
REQ-020 Round-robin mode: grant the first eligible channel strictly after the last granted index, wrapping from N_CH-1 to 0.
REQ-021 Round-robin pointer: reset value N_CH-1, so channel 0 is first; updated only on a grant; null packets do not update it.
REQ-022 IDLE with eligible = 0 and NULL_EN = 1: enter NULL; with NULL_EN = 0: remain in IDLE.
REQ-023 READ: RD_REQ[grant] SHALL be high for exactly PKT_LEN consecutive cycles; the FSM then returns to IDLE.
REQ-024 NULL: runs for PKT_LEN cycles; generated bytes are 47, 1F, FF, 10, then FF for the remaining PKT_LEN-4 bytes; the FSM then returns to IDLE.
REQ-025 Latency from RD_REQ (or null-byte generation cycle) to DATA_OUT/D_VALID_OUT SHALL be 2 cycles (FIFO read + output register), identical for READ and NULL.
REQ-026 Each packet leaves as PKT_LEN contiguous valid bytes; there is exactly one IDLE cycle (D_VALID_OUT low) between packets.
REQ-027 P_SYNC_OUT and ACTIVE_CH SHALL be aligned with DATA_OUT.
REQ-028 SYNC_ERR is aligned with that packet's first DATA_OUT byte; the packet is still forwarded complete.
REQ-029 Changes to CH_MASK, PRIO_MODE or NULL_EN mid-packet SHALL take effect only at the next IDLE arbitration.
REQ-030 GOT_FULL_PACKET falling during READ SHALL be ignored; the packet completes.
REQ-031 The byte counter SHALL be wide enough for PKT_LEN and SHALL clear on every entry to READ or NULL.

Reset
REQ-032 RST low SHALL asynchronously force: state IDLE, RD_REQ 0, DATA_OUT 8'h00, D_VALID_OUT 0, P_SYNC_OUT 0, ACTIVE_CH 4'hF, SYNC_ERR 0, round-robin pointer N_CH-1, byte counter 0.
REQ-033 Reset asserted mid-packet SHALL abort the packet; after release, no partial packet is resumed and arbitration restarts from IDLE.

Verification
REQ-034 All channels full, CH_MASK=F, PRIO_MODE=0: grants follow 0,1,2,3,0; each packet is 188 valid bytes with P_SYNC_OUT on the 47 byte and 1 gap cycle between packets.
REQ-035 Channels 1 and 3 full, PRIO_MODE=1: only channel 1 is granted while it stays full; ACTIVE_CH=1 throughout.
REQ-036 No channel full, NULL_EN=1: output is 47 1F FF 10 followed by 184×FF, ACTIVE_CH=F, repeating; with NULL_EN=0, D_VALID_OUT stays 0.
REQ-037 Channel 2 first byte 8'h46: SYNC_ERR pulses once, aligned with DATA_OUT=46, and all 188 bytes are forwarded.
REQ-038 RST pulsed low at byte 100 of a READ: outputs are at reset values immediately; after release, the next packet starts with a fresh P_SYNC_OUT and runs a full 188 bytes.
REQ-039 CH_MASK cleared for the active channel mid-packet: the packet completes all 188 bytes, and that channel is not granted again.

Source files
------------

// File: rtl/ts_packet_arbiter.sv
// ts_packet_arbiter
//   Picks one of N_CH transport-stream channel FIFOs, reads one complete
//   PKT_LEN-byte packet from it and forwards it on a single byte stream.
//   When no channel can be served and NULL_EN is set, a null packet
//   (47 1F FF 10 FF...) is generated instead.
//
// Ports
//   CLK             system clock, rising edge
//   RST             asynchronous active-low reset
//   CH_MASK         per-channel grant enable
//   PRIO_MODE       0 = round-robin, 1 = fixed priority (lowest index wins)
//   NULL_EN         generate null packets when nothing is eligible
//   GOT_FULL_PACKET channel i holds at least one complete packet
//   DATA_IN_BUS     channel i byte on [8i+7:8i]
//   RD_REQ          per-channel FIFO read strobe (one-hot or zero)
//   DATA_OUT        output byte
//   D_VALID_OUT     DATA_OUT valid
//   P_SYNC_OUT      first byte of each output packet
//   ACTIVE_CH       channel index of DATA_OUT, 4'hF for null/idle
//   SYNC_ERR        granted packet's first byte was not 8'h47
//   dbg_state       current FSM state (IDLE=0, READ=1, NULL=2)
//
// Handshake: there is no back-pressure. RD_REQ[i] high in cycle t means
// the FIFO presents its byte on DATA_IN_BUS lane i during cycle t+1; that
// byte is registered and appears on DATA_OUT with D_VALID_OUT in cycle t+2.
// Null bytes follow the same two-stage path so both packet kinds share
// one latency.
module ts_packet_arbiter #(
    parameter int N_CH    = 4,
    parameter int PKT_LEN = 188
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_CH-1:0]   CH_MASK,
    input  logic              PRIO_MODE,
    input  logic              NULL_EN,
    input  logic [N_CH-1:0]   GOT_FULL_PACKET,
    input  logic [8*N_CH-1:0] DATA_IN_BUS,
    output logic [N_CH-1:0]   RD_REQ,
    output logic [7:0]        DATA_OUT,
    output logic              D_VALID_OUT,
    output logic              P_SYNC_OUT,
    output logic [3:0]        ACTIVE_CH,
    output logic              SYNC_ERR,
    output logic [1:0]        dbg_state
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW = $clog2(PKT_LEN + 1);
    localparam logic [BW-1:0] LAST = BW'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_NULL = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [BW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   grant, grant_n;
    logic [CW-1:0]   rr_ptr, rr_ptr_n;
    logic [N_CH-1:0] eligible;
    logic [CW-1:0]   fix_sel, rr_sel;
    logic [7:0]      null_byte;

    // Stage 1: what the byte arriving on DATA_IN_BUS this cycle belongs to.
    logic            s1_valid, s1_null, s1_first;
    logic [CW-1:0]   s1_ch;
    logic [7:0]      s1_nbyte;
    logic [7:0]      sel_byte;

    assign eligible  = GOT_FULL_PACKET & CH_MASK;
    assign dbg_state = state;

    always_comb begin : pick
        int idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        fix_sel = '0;
        rr_sel  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i]) fix_sel = CW'(i);
        end
        // Search starts one past the last grant and wraps.
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                rr_sel = CW'(idx);
            end
        end
    end

    always_comb begin
        null_byte = 8'hFF;
        if (cnt == BW'(0))      null_byte = 8'h47;
        else if (cnt == BW'(1)) null_byte = 8'h1F;
        else if (cnt == BW'(3)) null_byte = 8'h10;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            grant  <= '0;
            rr_ptr <= CW'(N_CH - 1);
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            grant  <= grant_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        RD_REQ   = '0;
        case (state)
            ST_IDLE: begin
                // Counter is held at zero so every packet starts from byte 0.
                cnt_n = '0;
                if (|eligible) begin
                    state_n  = ST_READ;
                    grant_n  = PRIO_MODE ? fix_sel : rr_sel;
                    rr_ptr_n = grant_n;
                end else if (NULL_EN) begin
                    state_n = ST_NULL;
                end
            end
            ST_READ: begin
                RD_REQ[grant] = 1'b1;
                if (cnt == LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_NULL: begin
                if (cnt == LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s1_null  <= 1'b0;
            s1_first <= 1'b0;
            s1_ch    <= '0;
            s1_nbyte <= 8'h00;
        end else begin
            s1_valid <= (state != ST_IDLE);
            s1_null  <= (state == ST_NULL);
            s1_first <= (cnt == '0);
            s1_ch    <= grant;
            s1_nbyte <= null_byte;
        end
    end

    assign sel_byte = s1_null ? s1_nbyte : DATA_IN_BUS[8*s1_ch +: 8];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA_OUT    <= 8'h00;
            D_VALID_OUT <= 1'b0;
            P_SYNC_OUT  <= 1'b0;
            ACTIVE_CH   <= 4'hF;
            SYNC_ERR    <= 1'b0;
        end else begin
            DATA_OUT    <= s1_valid ? sel_byte : 8'h00;
            D_VALID_OUT <= s1_valid;
            P_SYNC_OUT  <= s1_valid & s1_first;
            ACTIVE_CH   <= (s1_valid && !s1_null) ? 4'(s1_ch) : 4'hF;
            // Only channel packets are checked; the packet is still forwarded.
            SYNC_ERR    <= s1_valid & s1_first & ~s1_null & (sel_byte != 8'h47);
        end
    end

endmodule

// File: tb/tb_ts_packet_arbiter.sv
module tb_ts_packet_arbiter;

    localparam int N_CH    = 4;
    localparam int PKT_LEN = 188;
    localparam int W       = 15;   // {gap_chk, data[7:0], sync, ch[3:0], err}

    // ---------------- clock / reset ----------------
    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [N_CH-1:0]   CH_MASK = '1;
    logic              PRIO_MODE = 1'b0;
    logic              NULL_EN = 1'b0;
    logic [N_CH-1:0]   GOT_FULL_PACKET = '0;
    logic [8*N_CH-1:0] DATA_IN_BUS = '0;
    logic [N_CH-1:0]   RD_REQ;
    logic [7:0]        DATA_OUT;
    logic              D_VALID_OUT;
    logic              P_SYNC_OUT;
    logic [3:0]        ACTIVE_CH;
    logic              SYNC_ERR;
    logic [1:0]        dbg_state;

    always #5 CLK = ~CLK;

    ts_packet_arbiter #(.N_CH(N_CH), .PKT_LEN(PKT_LEN)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .CH_MASK         (CH_MASK),
        .PRIO_MODE       (PRIO_MODE),
        .NULL_EN         (NULL_EN),
        .GOT_FULL_PACKET (GOT_FULL_PACKET),
        .DATA_IN_BUS     (DATA_IN_BUS),
        .RD_REQ          (RD_REQ),
        .DATA_OUT        (DATA_OUT),
        .D_VALID_OUT     (D_VALID_OUT),
        .P_SYNC_OUT      (P_SYNC_OUT),
        .ACTIVE_CH       (ACTIVE_CH),
        .SYNC_ERR        (SYNC_ERR),
        .dbg_state       (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- channel content ----------------
    function automatic logic [7:0] ch_byte(input int ch, input int k, input bit err);
        if (k == 0) return err ? 8'h46 : 8'h47;
        return 8'(ch * 50 + k);
    endfunction

    function automatic logic [7:0] null_byte(input int k);
        case (k)
            0:       return 8'h47;
            1:       return 8'h1F;
            3:       return 8'h10;
            default: return 8'hFF;
        endcase
    endfunction

    // FIFO model: answers a read strobe with the next byte one cycle later.
    logic [N_CH-1:0] req_seen = '0;
    int              rd_cnt [N_CH];
    bit              err_first [N_CH];

    always @(negedge CLK) req_seen = RD_REQ;

    always @(posedge CLK) begin
        #1;
        if (!RST) begin
            for (int i = 0; i < N_CH; i++) rd_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (req_seen[i]) begin
                    DATA_IN_BUS[8*i +: 8] = ch_byte(i, rd_cnt[i], err_first[i]);
                    rd_cnt[i] = (rd_cnt[i] + 1) % PKT_LEN;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    int           gap_cnt   = 0;
    int           sync_seen = 0;

    task automatic push_pkt(input int ch, input bit is_null, input bit err, input bit gap_chk);
        logic [7:0] d;
        logic [3:0] c;
        for (int k = 0; k < PKT_LEN; k++) begin
            d = is_null ? null_byte(k) : ch_byte(ch, k, err);
            c = is_null ? 4'hF : 4'(ch);
            exp_q.push_back({(gap_chk && k == 0), d, (k == 0), c, (err && k == 0)});
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            gap_cnt = 0;
        end else begin
            check_eq("rd_onehot", 32'($onehot0(RD_REQ)), 32'd1);
            if (D_VALID_OUT) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", 32'(D_VALID_OUT), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("beat", 32'({DATA_OUT, P_SYNC_OUT, ACTIVE_CH, SYNC_ERR}), 32'(mon_e[13:0]));
                    if (mon_e[14]) check_eq("gap", gap_cnt, 32'd1);
                    if (P_SYNC_OUT) sync_seen++;
                end
                gap_cnt = 0;
            end else begin
                // Valid may only drop between packets.
                if (exp_q.size() != 0 && exp_q[0][5] == 1'b0)
                    check_eq("contig", 32'(D_VALID_OUT), 32'd1);
                gap_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_syncs(input string tag, input int target, input int budget);
        int n = 0;
        while (sync_seen < target && n < budget) begin
            @(negedge CLK); #2;
            n++;
        end
        check_eq(tag, sync_seen, target);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK); #2;
            n++;
        end
        check_eq(tag, exp_q.size(), 32'd0);
        exp_q.delete();
        repeat (5) @(negedge CLK);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_req"},  32'(RD_REQ), 32'd0);
        check_eq({tag, "_data"},    32'(DATA_OUT), 32'h00);
        check_eq({tag, "_valid"},   32'(D_VALID_OUT), 32'd0);
        check_eq({tag, "_psync"},   32'(P_SYNC_OUT), 32'd0);
        check_eq({tag, "_active"},  32'(ACTIVE_CH), 32'hF);
        check_eq({tag, "_syncerr"}, 32'(SYNC_ERR), 32'd0);
        check_eq({tag, "_state"},   32'(dbg_state), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    int base;
    int valid_cnt;
    int hold;

    initial begin
        // Reset with every channel ready: nothing may move.
        GOT_FULL_PACKET = '1;
        repeat (3) @(negedge CLK);
        #2;
        check_reset_outputs("rst0");
        GOT_FULL_PACKET = '0;
        @(negedge CLK); #1;
        RST = 1'b1;

        // Nothing eligible, nulls off: output stays idle.
        valid_cnt = 0;
        repeat (60) begin
            @(negedge CLK); #2;
            if (D_VALID_OUT) valid_cnt++;
        end
        check_eq("idle_valid_cnt", valid_cnt, 32'd0);
        check_eq("idle_active", 32'(ACTIVE_CH), 32'hF);

        // Round-robin over four full channels: 0,1,2,3,0.
        push_pkt(0, 0, 0, 0);
        push_pkt(1, 0, 0, 1);
        push_pkt(2, 0, 0, 1);
        push_pkt(3, 0, 0, 1);
        push_pkt(0, 0, 0, 1);
        base = sync_seen;
        PRIO_MODE = 1'b0;
        CH_MASK = 4'hF;
        GOT_FULL_PACKET = 4'hF;
        wait_syncs("rr_syncs", base + 5, 5 * (PKT_LEN + 2) + 50);
        // Dropping during the last read must not cut it short.
        GOT_FULL_PACKET = 4'h0;
        drain("rr_drain", PKT_LEN + 50);

        // Fixed priority, channels 1 and 3: only 1 is served.
        push_pkt(1, 0, 0, 0);
        push_pkt(1, 0, 0, 1);
        push_pkt(1, 0, 0, 1);
        base = sync_seen;
        PRIO_MODE = 1'b1;
        GOT_FULL_PACKET = 4'b1010;
        wait_syncs("fix_syncs", base + 3, 3 * (PKT_LEN + 2) + 50);
        GOT_FULL_PACKET = 4'h0;
        drain("fix_drain", PKT_LEN + 50);

        // Null packets back to back; disabling mid-packet lets it finish.
        push_pkt(0, 1, 0, 0);
        push_pkt(0, 1, 0, 1);
        base = sync_seen;
        NULL_EN = 1'b1;
        wait_syncs("null_syncs", base + 2, 2 * (PKT_LEN + 2) + 50);
        NULL_EN = 1'b0;
        drain("null_drain", PKT_LEN + 50);

        // Channel 2 with a bad sync byte: flagged once, forwarded whole.
        PRIO_MODE = 1'b0;
        err_first[2] = 1'b1;
        push_pkt(2, 0, 1, 0);
        base = sync_seen;
        GOT_FULL_PACKET = 4'b0100;
        wait_syncs("err_syncs", base + 1, PKT_LEN + 50);
        GOT_FULL_PACKET = 4'h0;
        drain("err_drain", PKT_LEN + 50);
        err_first[2] = 1'b0;

        // Reset around byte 100 of a channel 0 packet.
        push_pkt(0, 0, 0, 0);
        base = sync_seen;
        GOT_FULL_PACKET = 4'b0001;
        wait_syncs("rst_syncs", base + 1, PKT_LEN + 50);
        hold = 97 + $urandom_range(0, 4);
        repeat (hold) @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        repeat (3) @(negedge CLK);
        #2;
        check_eq("rst_mid_hold_valid", 32'(D_VALID_OUT), 32'd0);
        push_pkt(0, 0, 0, 0);
        base = sync_seen;
        #1;
        RST = 1'b1;
        wait_syncs("rst_resume_syncs", base + 1, PKT_LEN + 50);
        GOT_FULL_PACKET = 4'h0;
        drain("rst_resume_drain", PKT_LEN + 50);

        // Mask the active channel mid-packet: it completes, then only 2 runs.
        push_pkt(1, 0, 0, 0);
        push_pkt(2, 0, 0, 1);
        push_pkt(2, 0, 0, 1);
        base = sync_seen;
        CH_MASK = 4'hF;
        GOT_FULL_PACKET = 4'b0110;
        wait_syncs("mask_syncs1", base + 1, PKT_LEN + 50);
        CH_MASK = 4'b1101;
        wait_syncs("mask_syncs3", base + 3, 3 * (PKT_LEN + 2) + 50);
        GOT_FULL_PACKET = 4'h0;
        drain("mask_drain", PKT_LEN + 50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
